player_motion_engine: RTL

- Parametrised, multi-level successor to the single-level block mover.
- Owns the player sprite position, vertical velocity (gravity and jump), lives, checkpoint and level index.
- Resolves collisions by querying the level-map ROM through a request/valid probe port. It no longer decodes hard-coded rectangles from hCount/vCount.
- Sits between the button debouncers/frame-tick generator and the VGA colouring logic. Advances once per frame.

---
 rtl/game_pkg.sv | 51 +++++
 rtl/map_probe_port.sv | 45 ++++
 rtl/player_motion_engine.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the player motion engine and the VGA colouring block.
// Tile classes, FSM encoding, screen bounds and palette live here so both sides agree.
package game_pkg;

    typedef enum logic [2:0] {
        TILE_EMPTY = 3'd0,
        TILE_SOLID = 3'd1,
        TILE_LAVA  = 3'd2,
        TILE_GOAL  = 3'd3,
        TILE_CKPT  = 3'd4
    } tile_class_e;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_WAIT,
        ST_PX,
        ST_PY,
        ST_PC,
        ST_DYING,
        ST_NEXT,
        ST_WIN,
        ST_OVER
    } state_e;

    localparam int SCR_H_MIN = 144;
    localparam int SCR_H_MAX = 783;
    localparam int SCR_V_MIN = 35;
    localparam int SCR_V_MAX = 515;

    localparam logic [11:0] COL_BG     = 12'h000;
    localparam logic [11:0] COL_PLAYER = 12'hFF0;
    localparam logic [11:0] COL_SOLID  = 12'h888;
    localparam logic [11:0] COL_LAVA   = 12'hF40;
    localparam logic [11:0] COL_GOAL   = 12'h0F0;
    localparam logic [11:0] COL_CKPT   = 12'h08F;

    // Bounds are always inside the visible screen, so the clamped value fits 10 bits.
    function automatic logic [9:0] clamp10(input logic signed [10:0] v,
                                           input logic signed [10:0] lo,
                                           input logic signed [10:0] hi);
        logic signed [10:0] r;
        if (v < lo)
            r = lo;
        else if (v > hi)
            r = hi;
        else
            r = v;
        return 10'(r);
    endfunction

endpackage

// File: rtl/map_probe_port.sv
// Level-map query port: latches the query point on start and holds probe_req until tile_valid.
// A response arriving while no request is outstanding (e.g. after reset) is ignored.
module map_probe_port (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    output logic       probe_req,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    input  logic       tile_valid,
    input  logic [2:0] tile_class,
    output logic       o_done,
    output logic [2:0] o_class
);

    logic       r_req;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       w_done;

    assign w_done = r_req && tile_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req <= 1'b0;
            r_x   <= '0;
            r_y   <= '0;
        end else if (i_start) begin
            r_req <= 1'b1;
            r_x   <= i_x;
            r_y   <= i_y;
        end else if (w_done) begin
            r_req <= 1'b0;
        end
    end

    assign probe_req = r_req;
    assign probe_x   = r_x;
    assign probe_y   = r_y;
    assign o_done    = w_done;
    assign o_class   = tile_class;

endmodule

// File: rtl/player_motion_engine.sv
// Per-frame player physics: horizontal step, gravity/jump, map-probed collisions,
// plus lives, checkpoint and level progression. Three probe handshakes per frame.
module player_motion_engine
    import game_pkg::*;
#(
    parameter int NUM_LEVELS   = 4,
    parameter int H_MIN        = SCR_H_MIN,
    parameter int H_MAX        = SCR_H_MAX,
    parameter int V_MIN        = SCR_V_MIN,
    parameter int V_MAX        = SCR_V_MAX,
    parameter int HALF         = 5,
    parameter int STEP         = 2,
    parameter int GRAV         = 1,
    parameter int JUMP_V       = 8,
    parameter int VMAX         = 6,
    parameter int VW           = 5,
    parameter int SPAWN_X      = 304,
    parameter int SPAWN_Y      = 220,
    parameter int LIVES        = 3,
    parameter int DEATH_FRAMES = 32,
    localparam int LW          = $clog2(NUM_LEVELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    output logic          probe_req,
    output logic [9:0]    probe_x,
    output logic [9:0]    probe_y,
    input  logic          tile_valid,
    input  logic [2:0]    tile_class,
    output logic [9:0]    xpos,
    output logic [9:0]    ypos,
    output logic [LW-1:0] level,
    output logic [1:0]    lives,
    output logic          dead_pulse,
    output logic          level_pulse,
    output logic          game_won,
    output logic          game_over,
    output logic          busy
);

    localparam int CW = $clog2(DEATH_FRAMES);
    localparam logic signed [10:0] X_LO = 11'(H_MIN + HALF);
    localparam logic signed [10:0] X_HI = 11'(H_MAX - HALF);
    localparam logic signed [10:0] Y_LO = 11'(V_MIN + HALF);
    localparam logic signed [10:0] Y_HI = 11'(V_MAX - HALF);
    localparam logic [9:0]  Y_FLOOR  = 10'(V_MAX - HALF);
    localparam logic [9:0]  HALF_10  = 10'(HALF);
    localparam logic signed [VW-1:0] VY_JUMP  = VW'(-JUMP_V);
    localparam logic signed [VW-1:0] VY_MAX   = VW'(VMAX);
    localparam logic signed [VW:0]   VY_MAX_W = (VW+1)'(VMAX);

    state_e                r_state;
    logic [9:0]            r_x, r_y, r_ckx, r_cky;
    logic signed [10:0]    r_nx;
    logic signed [VW-1:0]  r_vy;
    logic                  r_gr, r_issued;
    logic                  r_dead_pulse, r_level_pulse, r_won, r_over;
    logic [LW-1:0]         r_level;
    logic [1:0]            r_lives;
    logic [CW-1:0]         r_cnt;

    logic signed [10:0]    w_x11, w_y11, w_vy11, w_nx, w_ty;
    logic signed [VW:0]    w_vy_inc;
    logic signed [VW-1:0]  w_vy_next;
    logic                  w_x_skip, w_y_skip, w_start, w_done;
    logic [9:0]            w_qx, w_qy;
    logic [2:0]            w_class;

    assign w_x11    = {1'b0, r_x};
    assign w_y11    = {1'b0, r_y};
    assign w_vy11   = {{(11-VW){r_vy[VW-1]}}, r_vy};
    assign w_nx     = right ? w_x11 + 11'(STEP) : (left ? w_x11 - 11'(STEP) : w_x11);
    assign w_ty     = w_y11 + w_vy11;
    assign w_vy_inc = {r_vy[VW-1], r_vy} + (VW+1)'(GRAV);
    assign w_x_skip = (r_nx == w_x11);
    assign w_y_skip = (r_vy == '0) && r_gr;

    always_comb begin
        if (up && r_gr)
            w_vy_next = VY_JUMP;
        else if (!r_gr)
            w_vy_next = (w_vy_inc > VY_MAX_W) ? VY_MAX : w_vy_inc[VW-1:0];
        else
            w_vy_next = r_vy;
    end

    // Query point is the leading edge of the sprite in the direction of travel.
    always_comb begin
        w_start = 1'b0;
        w_qx    = r_x;
        w_qy    = r_y;
        case (r_state)
            ST_PX: begin
                w_start = !r_issued && !w_x_skip;
                w_qx    = (r_nx > w_x11) ? r_nx[9:0] + HALF_10 : r_nx[9:0] - HALF_10;
            end
            ST_PY: begin
                w_start = !r_issued && !w_y_skip;
                w_qy    = r_vy[VW-1] ? w_ty[9:0] - HALF_10 : w_ty[9:0] + HALF_10;
            end
            ST_PC:   w_start = !r_issued;
            default: w_start = 1'b0;
        endcase
    end

    map_probe_port u_probe (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_start),
        .i_x        (w_qx),
        .i_y        (w_qy),
        .probe_req  (probe_req),
        .probe_x    (probe_x),
        .probe_y    (probe_y),
        .tile_valid (tile_valid),
        .tile_class (tile_class),
        .o_done     (w_done),
        .o_class    (w_class)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_INIT;
            r_x           <= 10'(SPAWN_X);
            r_y           <= 10'(SPAWN_Y);
            r_ckx         <= 10'(SPAWN_X);
            r_cky         <= 10'(SPAWN_Y);
            r_nx          <= 11'(SPAWN_X);
            r_vy          <= '0;
            r_gr          <= 1'b0;
            r_issued      <= 1'b0;
            r_level       <= '0;
            r_lives       <= 2'(LIVES);
            r_cnt         <= '0;
            r_dead_pulse  <= 1'b0;
            r_level_pulse <= 1'b0;
            r_won         <= 1'b0;
            r_over        <= 1'b0;
        end else begin
            r_dead_pulse  <= 1'b0;
            r_level_pulse <= 1'b0;
            case (r_state)
                ST_INIT: if (down && frame_tick) r_state <= ST_WAIT;
                ST_WAIT: if (frame_tick) begin
                    r_nx    <= w_nx;
                    r_vy    <= w_vy_next;
                    r_state <= ST_PX;
                end
                ST_PX: if (!r_issued) begin
                    if (w_x_skip) r_state <= ST_PY;
                    else          r_issued <= 1'b1;
                end else if (w_done) begin
                    r_issued <= 1'b0;
                    if (w_class != TILE_SOLID) r_x <= clamp10(r_nx, X_LO, X_HI);
                    r_state  <= ST_PY;
                end
                ST_PY: if (!r_issued) begin
                    if (w_y_skip) r_state <= ST_PC;
                    else          r_issued <= 1'b1;
                end else if (w_done) begin
                    r_issued <= 1'b0;
                    r_state  <= ST_PC;
                    // Landing on the bottom clamp behaves exactly like a solid floor.
                    if (w_class == TILE_SOLID) begin
                        r_gr <= !r_vy[VW-1];
                        r_vy <= '0;
                    end else if (w_ty >= Y_HI) begin
                        r_y  <= Y_FLOOR;
                        r_gr <= 1'b1;
                        r_vy <= '0;
                    end else begin
                        r_y  <= clamp10(w_ty, Y_LO, Y_HI);
                        r_gr <= 1'b0;
                    end
                end
                ST_PC: if (!r_issued) begin
                    r_issued <= 1'b1;
                end else if (w_done) begin
                    r_issued <= 1'b0;
                    case (w_class)
                        TILE_LAVA: begin
                            r_state      <= ST_DYING;
                            r_dead_pulse <= 1'b1;
                            r_cnt        <= '0;
                        end
                        TILE_GOAL: r_state <= ST_NEXT;
                        TILE_CKPT: begin
                            r_ckx   <= r_x;
                            r_cky   <= r_y;
                            r_state <= ST_WAIT;
                        end
                        default:   r_state <= ST_WAIT;
                    endcase
                end
                ST_DYING: if (frame_tick) begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_y < Y_FLOOR) r_y <= r_y + 10'd1;
                    if (r_cnt == CW'(DEATH_FRAMES - 1)) begin
                        r_lives <= r_lives - 2'd1;
                        if (r_lives <= 2'd1) begin
                            r_state <= ST_OVER;
                            r_over  <= 1'b1;
                        end else begin
                            r_x     <= r_ckx;
                            r_y     <= r_cky;
                            r_vy    <= '0;
                            r_gr    <= 1'b0;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_NEXT: begin
                    r_level_pulse <= 1'b1;
                    if (r_level == LW'(NUM_LEVELS - 1)) begin
                        r_state <= ST_WIN;
                        r_won   <= 1'b1;
                    end else begin
                        r_level <= r_level + LW'(1);
                        r_x     <= 10'(SPAWN_X);
                        r_y     <= 10'(SPAWN_Y);
                        r_ckx   <= 10'(SPAWN_X);
                        r_cky   <= 10'(SPAWN_Y);
                        r_vy    <= '0;
                        r_gr    <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WIN:  r_state <= ST_WIN;
                ST_OVER: r_state <= ST_OVER;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign xpos        = r_x;
    assign ypos        = r_y;
    assign level       = r_level;
    assign lives       = r_lives;
    assign dead_pulse  = r_dead_pulse;
    assign level_pulse = r_level_pulse;
    assign game_won    = r_won;
    assign game_over   = r_over;
    assign busy        = !(r_state inside {ST_INIT, ST_WAIT, ST_WIN, ST_OVER});

endmodule
